// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues icache fetches, pre-decodes JAL/branches for
// immediate redirect, and buffers fetched words in a circular queue toward decode.
module inst_fetch_queue #(
  parameter int unsigned QUEUE_WIDTH = 3,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                   clockIn,
  input  logic                   resetIn,
  input  logic                   readyIn,
  output logic [31:0]            fetchAddrOut,
  output logic                   fetchValidOut,
  input  logic                   hit,
  input  logic [31:0]            icacheIn,
  output logic [31:0]            predPCOut,
  input  logic                   predictJump,
  output logic                   insValidOut,
  output logic [31:0]            insOut,
  output logic [31:0]            insPCOut,
  output logic                   insJumpOut,
  input  logic                   insReadyIn,
  input  logic                   clearIn,
  input  logic [31:0]            setPCVal,
  output logic [QUEUE_WIDTH:0]   countOut,
  output logic                   fullOut,
  output logic                   emptyOut
);

  localparam int unsigned DEPTH = 1 << QUEUE_WIDTH;
  localparam int unsigned CW    = QUEUE_WIDTH + 1;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [31:0]            fetch_addr_q, fetch_addr_d;
  logic [QUEUE_WIDTH-1:0] head_q, head_d;
  logic [QUEUE_WIDTH-1:0] tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;

  logic [31:0] ins_mem_q [DEPTH];
  logic [31:0] pc_mem_q  [DEPTH];
  logic        jmp_mem_q [DEPTH];

  logic        full, empty, fetch_valid;
  logic        push, pop, flush;
  logic        taken;
  logic [6:0]  opcode;
  logic [31:0] imm_j, imm_b;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == CW'(0));
  assign fetch_valid = (state_q == ST_FETCH) && !full;

  assign flush = clearIn && readyIn;
  assign push  = readyIn && fetch_valid && hit && !clearIn;
  assign pop   = readyIn && !empty && insReadyIn && !clearIn;

  assign opcode = icacheIn[6:0];
  assign imm_j  = {{11{icacheIn[31]}}, icacheIn[31], icacheIn[19:12], icacheIn[20],
                   icacheIn[30:21], 1'b0};
  assign imm_b  = {{19{icacheIn[31]}}, icacheIn[31], icacheIn[7], icacheIn[30:25],
                   icacheIn[11:8], 1'b0};

  // Pre-decode of the word being fetched: taken bit for the queue entry
  always_comb begin
    taken = 1'b0;
    if (opcode == OP_JAL) begin
      taken = 1'b1;
    end else if (opcode == OP_BRANCH) begin
      taken = predictJump;
    end
  end

  // Next-state: flush dominates, otherwise push/pop/redirect
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    if (flush) begin
      state_d      = ST_FETCH;
      fetch_addr_d = setPCVal;
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + QUEUE_WIDTH'(1);
        if (opcode == OP_JAL) begin
          fetch_addr_d = fetch_addr_q + imm_j;
        end else if ((opcode == OP_BRANCH) && predictJump) begin
          fetch_addr_d = fetch_addr_q + imm_b;
        end else begin
          fetch_addr_d = fetch_addr_q + 32'd4;
        end
        if (opcode == OP_JALR) begin
          state_d = ST_HOLD;
        end
      end
      if (pop) begin
        head_d = head_q + QUEUE_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q      <= ST_FETCH;
      fetch_addr_q <= RESET_PC;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else if (readyIn) begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

  // Queue storage needs no reset: contents are only visible when count is nonzero
  always_ff @(posedge clockIn) begin
    if (push) begin
      ins_mem_q[tail_q] <= icacheIn;
      pc_mem_q[tail_q]  <= fetch_addr_q;
      jmp_mem_q[tail_q] <= taken;
    end
  end

  assign fetchAddrOut  = fetch_addr_q;
  assign predPCOut     = fetch_addr_q;
  assign fetchValidOut = fetch_valid;
  assign insValidOut   = !empty;
  assign insOut        = empty ? 32'd0 : ins_mem_q[head_q];
  assign insPCOut      = empty ? 32'd0 : pc_mem_q[head_q];
  assign insJumpOut    = empty ? 1'b0  : jmp_mem_q[head_q];
  assign countOut      = count_q;
  assign fullOut       = full;
  assign emptyOut      = empty;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_fetch_queue;

  localparam int unsigned QW    = 3;
  localparam int unsigned DEPTH = 1 << QW;
  localparam logic [31:0] RPC   = 32'h0;

  localparam logic [31:0] ADDI = 32'h00000013;
  localparam logic [31:0] JAL  = 32'h1000006F;  // imm +0x100
  localparam logic [31:0] BEQ  = 32'hFE000CE3;  // imm -8
  localparam logic [31:0] JALR = 32'h00008067;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ready = 1'b1;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic        hit = 1'b0;
  logic [31:0] icache = ADDI;
  logic [31:0] pred_pc;
  logic        pj = 1'b0;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_jump;
  logic        ins_ready = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] set_pc = 32'h0;
  logic [QW:0] count;
  logic        full;
  logic        empty;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.QUEUE_WIDTH(QW), .RESET_PC(RPC)) dut (
    .clockIn(clk), .resetIn(rst_n), .readyIn(ready),
    .fetchAddrOut(fetch_addr), .fetchValidOut(fetch_valid),
    .hit(hit), .icacheIn(icache), .predPCOut(pred_pc), .predictJump(pj),
    .insValidOut(ins_valid), .insOut(ins), .insPCOut(ins_pc), .insJumpOut(ins_jump),
    .insReadyIn(ins_ready), .clearIn(clear), .setPCVal(set_pc),
    .countOut(count), .fullOut(full), .emptyOut(empty)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of fetched entries plus fetch PC and hold flag
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        jmp;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fa;
  bit          m_hold;

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w,
                                          input logic p, output logic tk);
    logic signed [20:0] jimm;
    logic signed [12:0] bimm;
    jimm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    bimm = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    tk = 1'b0;
    if (w[6:0] == 7'h6F) begin
      tk = 1'b1;
      return pc + unsigned'(int'(jimm));
    end
    if (w[6:0] == 7'h63 && p) begin
      tk = 1'b1;
      return pc + unsigned'(int'(bimm));
    end
    return pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_fa   = RPC;
      m_hold = 1'b0;
    end else if (ready) begin
      if (clear) begin
        mq.delete();
        m_fa   = set_pc;
        m_hold = 1'b0;
      end else begin
        bit   do_push, do_pop;
        logic tk;
        ent_t e;
        do_push = !m_hold && (mq.size() < DEPTH) && hit;
        do_pop  = (mq.size() > 0) && ins_ready;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          e.ins = icache;
          e.pc  = m_fa;
          m_fa  = next_pc(m_fa, icache, pj, tk);
          e.jmp = tk;
          mq.push_back(e);
          if (icache[6:0] == 7'h67) m_hold = 1'b1;
        end
      end
    end
  end

  // Compare every cycle away from the active edge
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      bit ne;
      ne = (mq.size() != 0);
      chk("fetchAddr", fetch_addr, m_fa);
      chk("predPC", pred_pc, m_fa);
      chk("fetchValid", 32'(fetch_valid), 32'(!m_hold && mq.size() < DEPTH));
      chk("insValid", 32'(ins_valid), 32'(ne));
      chk("ins", ins, ne ? mq[0].ins : 32'd0);
      chk("insPC", ins_pc, ne ? mq[0].pc : 32'd0);
      chk("insJump", 32'(ins_jump), ne ? 32'(mq[0].jmp) : 32'd0);
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(!ne));
    end
  end

  task automatic step(input logic r, input logic h, input logic [31:0] w, input logic p,
                      input logic ir, input logic c, input logic [31:0] sp);
    ready = r; hit = h; icache = w; pj = p; ins_ready = ir; clear = c; set_pc = sp;
    @(negedge clk);
  endtask

  task automatic restart(input logic [31:0] pc);
    step(1'b1, 1'b0, ADDI, 1'b0, 1'b0, 1'b1, pc);
  endtask

  initial begin
    logic [31:0] r, w;
    #1 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    @(negedge clk);
    check_en = 1'b1;

    // reset state and straight-line streaming
    chk("rst_fetchAddr", fetch_addr, 32'h0);
    chk("rst_fetchValid", 32'(fetch_valid), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    step(1, 1, ADDI, 0, 1, 0, 0);
    chk("t1_fetchAddr", fetch_addr, 32'h4);
    chk("t1_insValid", 32'(ins_valid), 32'd1);
    chk("t1_insPC0", ins_pc, 32'h0);
    step(1, 1, ADDI, 0, 1, 0, 0);
    chk("t1_insPC4", ins_pc, 32'h4);
    chk("t1_fetchAddr8", fetch_addr, 32'h8);

    // fill and drain
    restart(0);
    for (int i = 0; i < 8; i++) step(1, 1, ADDI, 0, 0, 0, 0);
    chk("t2_count8", 32'(count), 32'd8);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_fvalid0", 32'(fetch_valid), 32'd0);
    chk("t2_fa20", fetch_addr, 32'h20);
    step(1, 0, ADDI, 0, 1, 0, 0);
    chk("t2_count7", 32'(count), 32'd7);
    chk("t2_fvalid1", 32'(fetch_valid), 32'd1);

    // sustained push+pop with wrap
    restart(0);
    step(1, 1, ADDI, 0, 0, 0, 0);
    step(1, 1, ADDI, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, ADDI, 0, 1, 0, 0);
      chk("t3_count2", 32'(count), 32'd2);
      chk("t3_order", ins_pc, 32'(4 * i));
    end

    // redirects
    restart(32'h10);
    step(1, 1, JAL, 0, 0, 0, 0);
    chk("t4_jal_fa", fetch_addr, 32'h110);
    chk("t4_jal_jump", 32'(ins_jump), 32'd1);
    restart(32'h20);
    step(1, 1, BEQ, 1, 0, 0, 0);
    chk("t4_bt_fa", fetch_addr, 32'h18);
    chk("t4_bt_jump", 32'(ins_jump), 32'd1);
    restart(32'h20);
    step(1, 1, BEQ, 0, 0, 0, 0);
    chk("t4_bnt_fa", fetch_addr, 32'h24);
    chk("t4_bnt_jump", 32'(ins_jump), 32'd0);

    // JALR hold, then flush with a pending hit
    restart(32'h3C);
    step(1, 1, ADDI, 0, 0, 0, 0);
    step(1, 1, JALR, 0, 0, 0, 0);
    chk("t5_hold_fv", 32'(fetch_valid), 32'd0);
    step(1, 1, ADDI, 0, 1, 0, 0);
    chk("t5_hold_fa", fetch_addr, 32'h44);
    chk("t5_drain", 32'(count), 32'd1);
    restart(0);
    for (int i = 0; i < 5; i++) step(1, 1, ADDI, 0, 0, 0, 0);
    step(1, 1, ADDI, 0, 1, 1, 32'h200);
    chk("t5_fl_empty", 32'(empty), 32'd1);
    chk("t5_fl_count", 32'(count), 32'd0);
    chk("t5_fl_fa", fetch_addr, 32'h200);
    chk("t5_fl_fv", 32'(fetch_valid), 32'd1);

    // freeze, then asynchronous reset mid-cycle
    restart(0);
    for (int i = 0; i < 3; i++) step(1, 1, ADDI, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, ADDI, 0, 1, 1, 32'h80);
    chk("t6_frz_count", 32'(count), 32'd3);
    chk("t6_frz_fa", fetch_addr, 32'hC);
    step(1, 1, ADDI, 0, 0, 0, 0);
    chk("t6_count4", 32'(count), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ar_count", 32'(count), 32'd0);
    chk("t6_ar_empty", 32'(empty), 32'd1);
    chk("t6_ar_fa", fetch_addr, RPC);
    chk("t6_ar_pc", pred_pc, RPC);
    chk("t6_ar_fv", 32'(fetch_valid), 32'd1);
    chk("t6_ar_ins", ins, 32'd0);
    chk("t6_ar_inspc", ins_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      w = $urandom;
      case (r[3:0])
        4'd0, 4'd1: w[6:0] = 7'h6F;
        4'd2, 4'd3, 4'd4: w[6:0] = 7'h63;
        4'd5: w[6:0] = 7'h67;
        default: w[6:0] = 7'h13;
      endcase
      step((r[7:4] != 4'd0), r[8] | r[9], w, r[10],
           r[11] | (r[12] & r[13]), (r[19:16] == 4'd0) && r[20], $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
